// File: rtl/spn_sched.sv
// spn_sched: round-robin scheduler sharing one SPN crypto core among NUM_REQ
// requesters. A request (opcode, 16-bit data, 32-bit key) is accepted over a
// valid/ready handshake. It is issued to the core for one cycle. The scheduler
// then waits for the core result or for a timeout. The result goes back
// tagged with the index of the requester that sent it.
//
// Build option: define SPN_SCHED_FIXED_PRIO_EN to replace round-robin with a
// fixed priority arbiter, where the lowest valid index always wins.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready            per-requester handshake (ready one-hot or 0)
//   req_opcode/req_data/req_key    packed per-requester operation fields
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_data/rsp_status     owner index, result, 01 enc/10 dec/11 error
//   core_opcode/in_data/key        to core (opcode 00 idle, 01 enc, 10 dec)
//   core_out_data/core_valid       from core (valid 00 none/01/10/11 error)
module spn_sched #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [2*NUM_REQ-1:0]  req_opcode,
    input  logic [16*NUM_REQ-1:0] req_data,
    input  logic [32*NUM_REQ-1:0] req_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_data,
    output logic [1:0]            rsp_status,
    output logic [1:0]            core_opcode,
    output logic [15:0]           core_in_data,
    output logic [31:0]           core_key,
    input  logic [15:0]           core_out_data,
    input  logic [1:0]            core_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e         state_q;
    logic [IDW-1:0] last_q;
    logic [7:0]     cnt_q, cnt_d;
    logic [1:0]     core_opcode_q;
    logic [15:0]    core_in_data_q;
    logic [31:0]    core_key_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [15:0]    rsp_data_q;
    logic [1:0]     rsp_status_q;

    logic           win_vld;
    logic [IDW-1:0] win_idx;
    logic [1:0]     win_op;
    logic [15:0]    win_data;
    logic [31:0]    win_key;

    // Winner search. Both loops run from the lowest priority candidate to the
    // highest. Each later hit overwrites an earlier one, so the last hit is
    // the highest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
`ifdef SPN_SCHED_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[IDW'(i)]) begin
                win_vld = 1'b1;
                win_idx = IDW'(i);
            end
        end
`else
        for (int k = NUM_REQ; k >= 1; k--) begin
            int j;
            j = (int'(last_q) + k) % NUM_REQ;
            if (req_valid[IDW'(j)]) begin
                win_vld = 1'b1;
                win_idx = IDW'(j);
            end
        end
`endif
    end

    assign win_op   = req_opcode[{win_idx, 1'b0} +: 2];
    assign win_data = req_data[{win_idx, 4'b0} +: 16];
    assign win_key  = req_key[{win_idx, 5'b0} +: 32];
    assign cnt_d    = cnt_q + 8'd1;

    always_comb begin
        req_ready = '0;
        if (!reset && state_q == IDLE && win_vld)
            req_ready[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_q         <= IDW'(NUM_REQ - 1);
            cnt_q          <= '0;
            core_opcode_q  <= 2'b00;
            core_in_data_q <= '0;
            core_key_q     <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_data_q     <= '0;
            rsp_status_q   <= 2'b00;
        end else begin
            case (state_q)
                IDLE: if (win_vld) begin
                    last_q   <= win_idx;
                    rsp_id_q <= win_idx;
                    if (win_op == 2'b01 || win_op == 2'b10) begin
                        // Load the core port now so the opcode is visible
                        // during the single ISSUE cycle.
                        core_opcode_q  <= win_op;
                        core_in_data_q <= win_data;
                        core_key_q     <= win_key;
                        state_q        <= ISSUE;
                    end else begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b11;
                        rsp_data_q   <= '0;
                        state_q      <= RESP;
                    end
                end
                ISSUE: begin
                    core_opcode_q <= 2'b00;
                    cnt_q         <= '0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (core_valid != 2'b00) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= core_out_data;
                        rsp_status_q <= core_valid;
                        state_q      <= RESP;
                    end else if (cnt_d == 8'(TIMEOUT)) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_status_q <= 2'b11;
                        state_q      <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_opcode  = core_opcode_q;
    assign core_in_data = core_in_data_q;
    assign core_key     = core_key_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_status   = rsp_status_q;

endmodule

// File: tb/tb_spn_sched.sv
// tb_spn_sched: directed bench for spn_sched. A transaction-level reference
// model is updated on every negative edge, and every output is compared
// against it on that edge. A simple core responder with configurable latency
// answers issued operations. Each directed test then checks hand-computed
// literals: grant order, latencies, ids, data and status.
module tb_spn_sched;
    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_opcode = '0;
    logic [16*N-1:0] req_data = '0;
    logic [32*N-1:0] req_key = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_data;
    logic [1:0]      rsp_status;
    logic [1:0]      core_opcode;
    logic [15:0]     core_in_data;
    logic [31:0]     core_key;
    logic [15:0]     core_out_data = '0;
    logic [1:0]      core_valid = '0;

    spn_sched #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .core_opcode(core_opcode), .core_in_data(core_in_data), .core_key(core_key),
        .core_out_data(core_out_data), .core_valid(core_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic int qat(int q[$], int k);
        if (k < q.size()) return q[k];
        return -1;
    endfunction

    // ---------------- reference model ----------------
    int          m_ptr = N - 1;   // last granted requester
    int          m_phase = 0;     // 0 idle, 1 issue, 2 wait, 3 resp
    int          m_wait = 0;
    logic [1:0]  m_cop = '0;
    logic [15:0] m_cin = '0;
    logic [31:0] m_ckey = '0;
    logic        m_rv = 1'b0;
    logic [1:0]  m_id = '0;
    logic [1:0]  m_st = '0;
    logic [15:0] m_rd = '0;

    function automatic int pick();
`ifdef SPN_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (req_valid[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    // ---------------- observation logs ----------------
    int          cyc = 0;
    logic [N-1:0] gnt_last = '0;
    int          g_idx[$], g_cyc[$], r_id[$], r_st[$], r_cyc[$], r_rise[$], r_dat[$];
    int          co_cnt = 0;
    int          multi_rdy = 0;
    logic        rv_prev = 1'b0;

    always @(negedge clk) begin
        int w;
        logic [N-1:0] exp_rdy;
        logic [1:0] op;
        cyc++;
        w = pick();
        exp_rdy = '0;
        if (!reset && m_phase == 0 && w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("core_opcode", core_opcode, m_cop);
        chk("core_in_data", core_in_data, m_cin);
        chk("core_key", core_key, m_ckey);
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_rd);
            chk("rsp_status", rsp_status, m_st);
        end
        // DUT observation logs for the directed checks
        if ($countones(req_ready) > 1) multi_rdy++;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
        gnt_last = req_valid & req_ready;
        if (rsp_valid && !rv_prev) r_rise.push_back(cyc);
        rv_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            r_id.push_back(int'(rsp_id)); r_st.push_back(int'(rsp_status));
            r_dat.push_back(int'(rsp_data)); r_cyc.push_back(cyc);
        end
        if (core_opcode != 2'b00) co_cnt++;
        // advance the model across the coming posedge
        if (reset) begin
            m_ptr = N - 1; m_phase = 0; m_cop = '0; m_cin = '0; m_ckey = '0;
            m_rv = 1'b0; m_id = '0; m_rd = '0; m_st = '0;
        end else begin
            case (m_phase)
                0: if (w >= 0) begin
                    op = req_opcode[2*w +: 2];
                    m_ptr = w;
                    m_id = 2'(w);
                    if (op == 2'b01 || op == 2'b10) begin
                        m_cop = op; m_cin = req_data[16*w +: 16]; m_ckey = req_key[32*w +: 32];
                        m_phase = 1;
                    end else begin
                        m_rv = 1'b1; m_st = 2'b11; m_rd = '0; m_phase = 3;
                    end
                end
                1: begin m_cop = '0; m_wait = 0; m_phase = 2; end
                2: begin
                    m_wait++;
                    if (core_valid != 2'b00) begin
                        m_rd = core_out_data; m_st = core_valid; m_rv = 1'b1; m_phase = 3;
                    end else if (m_wait == TO) begin
                        m_rd = '0; m_st = 2'b11; m_rv = 1'b1; m_phase = 3;
                    end
                end
                default: if (rsp_ready) begin m_rv = 1'b0; m_phase = 0; end
            endcase
        end
    end

    // ---------------- core responder ----------------
    int          core_delay = 1;
    bit          core_mute = 1'b0;
    logic [15:0] core_xor = 16'hFFFF;
    logic [1:0]  inj_cv = '0;
    int          cd = 0;
    logic [1:0]  cop_cap = '0;
    logic [15:0] cin_cap = '0;

    always @(posedge clk) begin
        #1;
        core_valid = inj_cv;
        core_out_data = '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin core_valid = cop_cap; core_out_data = cin_cap ^ core_xor; end
        end
        if (core_opcode != 2'b00 && !core_mute) begin
            cd = core_delay; cop_cap = core_opcode; cin_cap = core_in_data;
        end
    end

    // ---------------- stimulus ----------------
    bit auto_drop = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~gnt_last;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(int i, logic [1:0] op, logic [15:0] d, logic [31:0] k);
        req_opcode[2*i +: 2] = op;
        req_data[16*i +: 16] = d;
        req_key[32*i +: 32]  = k;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(string nm, int n, int budget);
        int t = 0;
        while (r_cyc.size() < n && t < budget) begin tick(); t++; end
        chk(nm, r_cyc.size() >= n, 1);
    endtask

    task automatic clr();
        g_idx.delete(); g_cyc.delete(); r_id.delete(); r_st.delete();
        r_cyc.delete(); r_rise.delete(); r_dat.delete(); co_cnt = 0;
    endtask

    initial begin
        // reset with every requester asking: nothing may be granted
        reset = 1'b1;
        req_valid = '1;
        req_opcode = {N{2'b01}};
        ticks(3);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_core_opcode", core_opcode, 0);
        chk("rst_core_in_data", core_in_data, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_status", rsp_status, 0);
        req_valid = '0;
        tick();
        reset = 1'b0;

        // 1: single encrypt, core answers two cycles after issue
        clr();
        core_delay = 2;
        core_xor = 16'h1234 ^ 16'hBEEF;
        set_req(2, 2'b01, 16'h1234, 32'hA5A5_0F0F);
        wait_rsp("t1_rsp_budget", 1, 40);
        ticks(3);
        chk("t1_grant_count", g_idx.size(), 1);
        chk("t1_grant_idx", qat(g_idx, 0), 2);
        chk("t1_core_op_cycles", co_cnt, 1);
        chk("t1_rsp_id", qat(r_id, 0), 2);
        chk("t1_rsp_data", qat(r_dat, 0), 32'hBEEF);
        chk("t1_rsp_status", qat(r_st, 0), 1);
        chk("t1_latency", qat(r_rise, 0) - qat(g_cyc, 0), 4);

        // 2: all requesters held valid, core answers immediately
        clr();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        core_delay = 1;
        core_xor = 16'hFFFF;
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 2'b01, 16'(16'h1111 * (i + 1)), 32'(i));
        wait_rsp("t2_rsp_budget", 6, 200);
        req_valid = '0;
        auto_drop = 1'b1;
        ticks(20);
        for (int k = 0; k < 6; k++) begin
`ifdef SPN_SCHED_FIXED_PRIO_EN
            chk($sformatf("t2_grant%0d", k), qat(g_idx, k), 0);
`else
            chk($sformatf("t2_grant%0d", k), qat(g_idx, k), k % 4);
`endif
        end
        chk("t2_min_latency", qat(r_rise, 0) - qat(g_cyc, 0), 3);
        chk("t2_one_hot_ready", multi_rdy, 0);

        // 3: decrypt with silent core, timeout, then late core_valid ignored
        clr();
        core_mute = 1'b1;
        set_req(1, 2'b10, 16'h5555, 32'h0000_0001);
        wait_rsp("t3_rsp_budget", 1, 60);
        chk("t3_timeout_latency", qat(r_rise, 0) - qat(g_cyc, 0), 18);
        chk("t3_rsp_id", qat(r_id, 0), 1);
        chk("t3_rsp_status", qat(r_st, 0), 3);
        chk("t3_rsp_data", qat(r_dat, 0), 0);
        inj_cv = 2'b10;
        ticks(3);
        inj_cv = 2'b00;
        ticks(5);
        chk("t3_no_second_rsp", r_cyc.size(), 1);
        core_mute = 1'b0;

        // 4: illegal opcode answered directly, core untouched
        clr();
        set_req(3, 2'b11, 16'h9999, 32'hDEAD_BEEF);
        wait_rsp("t4_rsp_budget", 1, 20);
        ticks(2);
        chk("t4_latency", qat(r_rise, 0) - qat(g_cyc, 0), 1);
        chk("t4_rsp_id", qat(r_id, 0), 3);
        chk("t4_rsp_status", qat(r_st, 0), 3);
        chk("t4_core_op_cycles", co_cnt, 0);

        // 5: response back-pressure while another request waits
        clr();
        rsp_ready = 1'b0;
        core_delay = 1;
        set_req(2, 2'b01, 16'hCAFE, 32'h1357_9BDF);
        begin
            int t = 0;
            while (!rsp_valid && t < 20) begin tick(); t++; end
        end
        chk("t5_rsp_seen", rsp_valid, 1);
        set_req(0, 2'b01, 16'h0BAD, 32'h2468_ACE0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_id", rsp_id, 2);
            chk("t5_hold_data", rsp_data, 16'hCAFE ^ 16'hFFFF);
            chk("t5_hold_status", rsp_status, 1);
            chk("t5_hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        wait_rsp("t5_rsp_budget", 2, 40);
        chk("t5_second_grant", qat(g_idx, 1), 0);
        chk("t5_grant_after_hs", qat(g_cyc, 1) - qat(r_cyc, 0), 1);
        ticks(3);

        // 6: reset during WAIT, then lowest valid index wins
        clr();
        core_mute = 1'b1;
        set_req(1, 2'b01, 16'h7777, 32'h0000_0002);
        ticks(5);
        set_req(1, 2'b01, 16'h7777, 32'h0000_0002);
        set_req(3, 2'b10, 16'h3333, 32'h0000_0003);
        reset = 1'b1;
        tick();
        chk("t6_core_opcode", core_opcode, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        #1;
        chk("t6_first_grant", req_ready, 4'b0010);
        core_mute = 1'b0;
        wait_rsp("t6_rsp_budget", 2, 60);
        chk("t6_grant_a", qat(g_idx, 1), 1);
        chk("t6_grant_b", qat(g_idx, 2), 3);
        chk("t6_rsp_a", qat(r_id, 0), 1);
        chk("t6_rsp_b", qat(r_id, 1), 3);
        chk("t6_rsp_b_status", qat(r_st, 1), 2);
        ticks(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule

// File: doc/spn_sched.md
Name: spn_sched

Overview:
- Round-robin scheduler that shares one SPN cryptographic core between NUM_REQ requesters.
- Each requester submits an operation (opcode, 16-bit data, 32-bit key) over a valid/ready handshake.
- The scheduler issues one operation at a time to the core, waits for the core's result or a timeout, and returns the result tagged with the requester index.
- Sits between the requester fabric and the SPN core port (opcode/in_data/key/out_data/valid).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum WAIT cycles before a timeout error (1..255).
- IDW, $clog2(NUM_REQ), requester index width (derived; not overridden).

Ports:
- clk  input  1  clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- req_opcode  input  2*NUM_REQ  packed opcodes; slice i = [2i+1:2i]
- req_data  input  16*NUM_REQ  packed input blocks
- req_key  input  32*NUM_REQ  packed keys
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  IDW  index of the requester that owns the response
- rsp_data  output  16  result block
- rsp_status  output  2  01 encrypt done, 10 decrypt done, 11 error
- core_opcode  output  2  to core: 00 idle, 01 encrypt, 10 decrypt
- core_in_data  output  16  to core
- core_key  output  32  to core
- core_out_data  input  16  from core
- core_valid  input  2  from core: 00 none, 01 enc, 10 dec, 11 core error

Behaviour:
- Reset values:
  - Registered outputs: core_opcode=00, core_in_data=0, core_key=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_status=00.
  - Combinational output: req_ready=0 while reset is high.
  - Internal: state=IDLE; last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first index with req_valid set, searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[winner] is driven combinationally high in the same cycle; the handshake completes that cycle.
  - On handshake: capture the winner's opcode/data/key; set last_grant=winner.
  - Captured opcode 01/10 -> ISSUE.
  - Captured opcode 00/11 -> RESP directly with rsp_status=11, rsp_data=0; the core is not touched.
  - No req_valid: stay in IDLE, all req_ready=0.
- ISSUE:
  - Exactly one cycle.
  - core_opcode = captured opcode; core_in_data/core_key = captured values.
  - Next state WAIT. core_opcode returns to 00 on entering WAIT.
  - core_in_data/core_key hold their values until the next issue.
- WAIT:
  - 8-bit counter cleared on entry, incremented each WAIT cycle.
  - First cycle with core_valid != 00: latch rsp_data=core_out_data, rsp_status=core_valid; go RESP.
  - Counter reaches TIMEOUT with core_valid == 00: rsp_status=11, rsp_data=0; go RESP.
  - core_valid outside WAIT (late, spurious) is ignored.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_status stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid=0 next cycle; go IDLE.
  - rsp_ready low: hold indefinitely. No new request is accepted while in RESP.
- Latency:
  - Handshake in cycle N; core_opcode valid in N+1; WAIT from N+2.
  - core_valid in cycle W gives rsp_valid in W+1.
  - Minimum accept-to-rsp_valid = 3 cycles (core_valid in N+2).
  - Illegal opcode: rsp_valid in N+1.
- Simultaneous requests: exactly one granted per IDLE visit; the others keep req_valid high and are served in rotating order.
- Reset mid-operation: any state returns to IDLE next cycle. The in-flight op and its response are discarded, core_opcode is forced to 00, and the priority pointer is reset.

Optional Feature:
- Macro: SPN_SCHED_FIXED_PRIO_EN.
- Defined: the winner is always the lowest index with req_valid high; last_grant is unused. Requester 0 can starve the others.
- Undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then req 2 valid with opcode 01, data 16'h1234, key 32'hA5A5_0F0F; core returns valid=01, out=16'hBEEF two cycles after issue -> core_opcode=01 for one cycle; rsp_valid with id=2, data=BEEF, status=01; req_ready[2] pulses once.
2. All 4 requesters held valid continuously after reset, core answering each op immediately -> grant order 0,1,2,3,0,1; never two req_ready bits high. With SPN_SCHED_FIXED_PRIO_EN -> always 0.
3. Req 1 opcode 10; core never asserts valid; TIMEOUT=16 -> rsp after 16 WAIT cycles, status=11, data=0, id=1. core_valid=10 injected afterwards -> ignored, no second response.
4. Req 3 opcode 11 -> rsp_valid one cycle after the handshake, status=11; core_opcode stays 00 throughout.
5. Response ready, rsp_ready held low 5 cycles while req 0 is valid -> outputs stable, req_ready all 0; rsp_ready high -> handshake, then req 0 accepted in the following IDLE cycle.
6. reset pulsed during WAIT -> next cycle state IDLE, core_opcode=00, rsp_valid=0; subsequent grant goes to the lowest valid index.
